// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson-counter consumers.
//   jc_state_e   : lock FSM state encoding (unlocked, acquiring, locked)
//   JcDefaultW   : default Johnson counter width
//   jc_next_idx  : legal successor of a phase index for a width-w counter
package johnson_pkg;

    localparam int unsigned JcDefaultW = 4;

    typedef enum logic [1:0] {
        StUnlocked,
        StAcquire,
        StLocked
    } jc_state_e;

    // A width-w Johnson counter cycles through 2*w phases.
    function automatic int unsigned jc_next_idx(input int unsigned idx, input int unsigned w);
        return (idx + 32'd1 >= 2 * w) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code decoder.
//   q_i     : Johnson code, bit 0 is the first bit filled
//   legal_o : q_i is one of the 2*W legal codes
//   idx_o   : phase index 0..2*W-1 (0 when illegal)
// Fill phase 1^k 0^(W-k) -> k; drain phase 0^j 1^(W-j) -> W+j.
module johnson_code_decode #(
    parameter int unsigned W = 4
) (
    input  logic [0:W-1]           q_i,
    output logic                   legal_o,
    output logic [$clog2(2*W)-1:0] idx_o
);

    localparam int unsigned IdxW = $clog2(2 * W);

    // First n bits equal to ~inv, the rest equal to inv.
    function automatic logic [0:W-1] fill_pat(input int unsigned n, input logic inv);
        logic [0:W-1] p;
        for (int unsigned i = 0; i < W; i++) begin
            p[i] = ((i < n) ? 1'b1 : 1'b0) ^ inv;
        end
        return p;
    endfunction

    always_comb begin
        legal_o = 1'b0;
        idx_o   = '0;
        for (int unsigned k = 0; k <= W; k++) begin
            if (q_i == fill_pat(k, 1'b0)) begin
                legal_o = 1'b1;
                idx_o   = IdxW'(k);
            end
        end
        for (int unsigned j = 1; j < W; j++) begin
            if (q_i == fill_pat(j, 1'b1)) begin
                legal_o = 1'b1;
                idx_o   = IdxW'(W + j);
            end
        end
    end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor.
//   clk, rst    : clock and asynchronous active-high reset
//   q_in        : Johnson code from the counter under observation
//   phase       : registered phase index, valid when phase_vld
//   phase_vld   : sampled code was legal
//   locked      : lock FSM is in the locked state
//   rev_tick    : one-cycle pulse on a 2W-1 -> 0 wrap while locked
//   seq_err     : one-cycle pulse on an illegal code or illegal step
//   rev_cnt     : saturating revolution count (while locked)
//   err_cnt     : saturating seq_err count
// Two register stages: q_in -> q_s, q_s -> all outputs.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int unsigned W      = JcDefaultW,
    parameter int unsigned LOCK_N = 3,
    parameter int unsigned STRICT = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [0:W-1]           q_in,
    output logic [$clog2(2*W)-1:0] phase,
    output logic                   phase_vld,
    output logic                   locked,
    output logic                   rev_tick,
    output logic                   seq_err,
    output logic [CNT_W-1:0]       rev_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int unsigned      IdxW    = $clog2(2 * W);
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(2 * W - 1);
    localparam logic [3:0]       LockN   = 4'(LOCK_N);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    logic [0:W-1]     q_s_q;
    // q_s holds a real sample; keeps the reset value of q_s from being decoded.
    logic             q_s_vld_q;
    logic [IdxW-1:0]  prev_q;
    logic             prev_ok_q;
    jc_state_e        state_q;
    logic [3:0]       good_cnt_q;
    logic [IdxW-1:0]  phase_q;
    logic             phase_vld_q;
    logic             locked_q;
    logic             rev_tick_q;
    logic             seq_err_q;
    logic [CNT_W-1:0] rev_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic            dec_legal;
    logic [IdxW-1:0] dec_idx;
    logic [IdxW-1:0] next_idx;
    logic            step_succ;
    logic            step_hold;
    logic            step_err;
    logic            step_wrap;

    johnson_code_decode #(
        .W (W)
    ) u_decode (
        .q_i     (q_s_q),
        .legal_o (dec_legal),
        .idx_o   (dec_idx)
    );

    always_comb begin
        next_idx  = IdxW'(jc_next_idx(32'(prev_q), W));
        step_succ = dec_legal && prev_ok_q && (dec_idx == next_idx);
        step_hold = (STRICT == 0) && dec_legal && prev_ok_q && (dec_idx == prev_q);
        step_err  = !dec_legal || (prev_ok_q && !step_succ && !step_hold);
        step_wrap = step_succ && (prev_q == LastIdx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_s_q       <= '0;
            q_s_vld_q   <= 1'b0;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            state_q     <= StUnlocked;
            good_cnt_q  <= '0;
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            rev_tick_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            rev_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            q_s_q     <= q_in;
            q_s_vld_q <= 1'b1;
            if (q_s_vld_q) begin
                prev_ok_q   <= dec_legal;
                phase_vld_q <= dec_legal;
                seq_err_q   <= step_err;
                rev_tick_q  <= 1'b0;
                if (dec_legal) begin
                    prev_q  <= dec_idx;
                    phase_q <= dec_idx;
                end
                if (step_err && err_cnt_q != CntMax) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
                case (state_q)
                    StUnlocked: begin
                        locked_q <= 1'b0;
                        if (dec_legal && !step_err) begin
                            state_q    <= StAcquire;
                            good_cnt_q <= '0;
                        end
                    end
                    StAcquire: begin
                        if (step_err) begin
                            state_q    <= StUnlocked;
                            good_cnt_q <= '0;
                            locked_q   <= 1'b0;
                        end else if (step_succ) begin
                            good_cnt_q <= good_cnt_q + 4'd1;
                            // The locking step never ticks, even on a wrap.
                            if (good_cnt_q + 4'd1 == LockN) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                    StLocked: begin
                        if (step_err) begin
                            state_q    <= StUnlocked;
                            good_cnt_q <= '0;
                            locked_q   <= 1'b0;
                        end else if (step_wrap) begin
                            rev_tick_q <= 1'b1;
                            if (rev_cnt_q != CntMax) begin
                                rev_cnt_q <= rev_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q  <= StUnlocked;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign phase     = phase_q;
    assign phase_vld = phase_vld_q;
    assign locked    = locked_q;
    assign rev_tick  = rev_tick_q;
    assign seq_err   = seq_err_q;
    assign rev_cnt   = rev_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Bench for johnson_phase_monitor: three instances (default, STRICT=0, CNT_W=2) share
// the stimulus; a behavioural model pushes expected outputs into a queue per driven code,
// and a negedge monitor pops and compares once the two-cycle latency has elapsed.
module tb_johnson_phase_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:3] q_in = '0;

    logic [2:0] ph_a, ph_b, ph_c;
    logic       vld_a, vld_b, vld_c, lk_a, lk_b, lk_c;
    logic       tk_a, tk_b, tk_c, se_a, se_b, se_c;
    logic [7:0] rc_a, ec_a, rc_b, ec_b;
    logic [1:0] rc_c, ec_c;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    always #5 clk = ~clk;

    johnson_phase_monitor #(.W(4), .LOCK_N(3), .STRICT(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .q_in(q_in), .phase(ph_a), .phase_vld(vld_a), .locked(lk_a),
        .rev_tick(tk_a), .seq_err(se_a), .rev_cnt(rc_a), .err_cnt(ec_a)
    );
    johnson_phase_monitor #(.W(4), .LOCK_N(3), .STRICT(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .q_in(q_in), .phase(ph_b), .phase_vld(vld_b), .locked(lk_b),
        .rev_tick(tk_b), .seq_err(se_b), .rev_cnt(rc_b), .err_cnt(ec_b)
    );
    johnson_phase_monitor #(.W(4), .LOCK_N(3), .STRICT(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .q_in(q_in), .phase(ph_c), .phase_vld(vld_c), .locked(lk_c),
        .rev_tick(tk_c), .seq_err(se_c), .rev_cnt(rc_c), .err_cnt(ec_c)
    );

    typedef struct packed {
        logic [2:0] phase;
        logic       vld;
        logic       locked;
        logic       tick;
        logic       err;
        logic [7:0] rev;
        logic [7:0] errc;
    } out_t;

    typedef struct packed {
        out_t a;
        out_t b;
        out_t c;
    } exp_t;

    typedef struct {
        int   st;    // 0 unlocked, 1 acquire, 2 locked
        int   prev;
        bit   pok;
        int   good;
        out_t o;
    } mst_t;

    logic [0:3] jc [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                           4'b1111, 4'b0111, 4'b0011, 4'b0001};
    logic [0:3] ill = 4'b1010;

    mst_t ma, mb, mc;
    exp_t sb [$];

    function automatic mst_t mreset();
        mst_t s;
        s.st = 0; s.prev = 0; s.pok = 1'b0; s.good = 0; s.o = '0;
        return s;
    endfunction

    function automatic int jdec(logic [0:3] q);
        case (q)
            4'b0000: return 0;
            4'b1000: return 1;
            4'b1100: return 2;
            4'b1110: return 3;
            4'b1111: return 4;
            4'b0111: return 5;
            4'b0011: return 6;
            4'b0001: return 7;
            default: return -1;
        endcase
    endfunction

    function automatic mst_t mstep(mst_t s, logic [0:3] q, bit strict, int cmax);
        mst_t n = s;
        int   idx = jdec(q);
        bit   legal = (idx >= 0);
        bit   succ = legal && s.pok && (idx == (s.prev + 1) % 8);
        bit   hold = legal && s.pok && !strict && (idx == s.prev);
        bit   err = !legal || (s.pok && !succ && !hold);
        n.o.tick = 1'b0;
        n.o.err  = err;
        n.o.vld  = legal;
        if (legal) n.o.phase = 3'(idx);
        if (err && int'(n.o.errc) < cmax) n.o.errc = n.o.errc + 8'd1;
        case (s.st)
            0: if (legal && !err) begin n.st = 1; n.good = 0; end
            1: begin
                if (err) begin n.st = 0; n.good = 0; end
                else if (succ) begin
                    n.good = s.good + 1;
                    if (n.good == 3) n.st = 2;
                end
            end
            default: begin
                if (err) begin n.st = 0; n.good = 0; end
                else if (succ && s.prev == 7) begin
                    n.o.tick = 1'b1;
                    if (int'(n.o.rev) < cmax) n.o.rev = n.o.rev + 8'd1;
                end
            end
        endcase
        n.o.locked = (n.st == 2);
        if (legal) n.prev = idx;
        n.pok = legal;
        return n;
    endfunction

    // Entered just after a posedge; returns just after the next one.
    task automatic step(input logic [0:3] code);
        exp_t e;
        q_in = code;
        ma = mstep(ma, code, 1'b1, 255);
        mb = mstep(mb, code, 1'b0, 255);
        mc = mstep(mc, code, 1'b1, 3);
        e.a = ma.o; e.b = mb.o; e.c = mc.o;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            step(jc[cur]);
            cur = (cur + 1) % 8;
        end
    endtask

    // Outputs of the code driven two steps back are visible at this negedge.
    always @(negedge clk) begin
        if (sb.size() >= 3) begin
            exp_t e;
            out_t act_a, act_b, act_c;
            e = sb.pop_front();
            act_a = {ph_a, vld_a, lk_a, tk_a, se_a, rc_a, ec_a};
            act_b = {ph_b, vld_b, lk_b, tk_b, se_b, rc_b, ec_b};
            act_c = {ph_c, vld_c, lk_c, tk_c, se_c, 6'd0, rc_c, 6'd0, ec_c};
            if (act_a !== e.a) begin
                $display("FAIL sb_strict got=%h exp=%h t=%0t", act_a, e.a, $time); bad++;
            end
            if (act_b !== e.b) begin
                $display("FAIL sb_lenient got=%h exp=%h t=%0t", act_b, e.b, $time); bad++;
            end
            if (act_c !== e.c) begin
                $display("FAIL sb_cnt2 got=%h exp=%h t=%0t", act_c, e.c, $time); bad++;
            end
            total += 3;
        end
    end

    task automatic test_reset();
        @(posedge clk);
        #1;
        if ({ph_a, vld_a, lk_a, tk_a, se_a, rc_a, ec_a} !== '0) begin
            $display("FAIL reset_outputs got=%h exp=0", {ph_a, vld_a, lk_a, tk_a, se_a, rc_a, ec_a});
            bad++;
        end
        total++;
        ma = mreset(); mb = mreset(); mc = mreset();
        rst = 1'b0;
        cur = 0;
    endtask

    task automatic test_lock_and_rev();
        for (int i = 1; i <= 33; i++) begin
            step(jc[(i - 1) % 8]);
            if (i == 1) begin
                if (vld_a !== 1'b0) begin $display("FAIL vld_cycle1 got=%b exp=0", vld_a); bad++; end
                total++;
            end
            if (i == 2) begin
                if (vld_a !== 1'b1 || ph_a !== 3'd0) begin
                    $display("FAIL vld_cycle2 got=%b/%0d exp=1/0", vld_a, ph_a); bad++;
                end
                total++;
            end
            if (i == 4) begin
                if (lk_a !== 1'b0) begin $display("FAIL lock_cycle4 got=%b exp=0", lk_a); bad++; end
                total++;
            end
            if (i == 5) begin
                if (lk_a !== 1'b1) begin $display("FAIL lock_cycle5 got=%b exp=1", lk_a); bad++; end
                total++;
            end
            if (i == 10 || i == 11) begin
                if (tk_a !== (i == 10)) begin
                    $display("FAIL rev_tick_%0d got=%b exp=%b", i, tk_a, (i == 10)); bad++;
                end
                total++;
            end
        end
        if (rc_a !== 8'd3) begin $display("FAIL rev_cnt3 got=%0d exp=3", rc_a); bad++; end
        total++;
        cur = 1;
    endtask

    task automatic test_bad_step();
        step(jc[1]); step(jc[2]); step(jc[5]); step(jc[6]);
        if (se_a !== 1'b1 || lk_a !== 1'b0 || ec_a !== 8'd1) begin
            $display("FAIL bad_step got=%b/%b/%0d exp=1/0/1", se_a, lk_a, ec_a); bad++;
        end
        total++;
        step(jc[7]);
        if (se_a !== 1'b0) begin $display("FAIL bad_step_once got=%b exp=0", se_a); bad++; end
        total++;
        step(jc[0]); step(jc[1]);
        if (lk_a !== 1'b0) begin $display("FAIL relock_early got=%b exp=0", lk_a); bad++; end
        total++;
        step(jc[2]);
        if (lk_a !== 1'b1) begin $display("FAIL relock got=%b exp=1", lk_a); bad++; end
        total++;
        cur = 3;
    endtask

    task automatic test_illegal();
        step(jc[3]); step(ill); step(jc[4]);
        if (vld_a !== 1'b0 || ph_a !== 3'd3 || se_a !== 1'b1 || ec_a !== 8'd2) begin
            $display("FAIL illegal got=%b/%0d/%b/%0d exp=0/3/1/2", vld_a, ph_a, se_a, ec_a); bad++;
        end
        total++;
        step(jc[5]);
        if (se_a !== 1'b0 || vld_a !== 1'b1 || ph_a !== 3'd4 || ec_a !== 8'd2) begin
            $display("FAIL illegal_recover got=%b/%b/%0d/%0d exp=0/1/4/2", se_a, vld_a, ph_a, ec_a);
            bad++;
        end
        total++;
        cur = 6;
        adv(4);
        if (lk_a !== 1'b1) begin $display("FAIL relock2 got=%b exp=1", lk_a); bad++; end
        total++;
    endtask

    task automatic test_hold();
        step(jc[2]); step(jc[2]); step(jc[3]);
        if (se_a !== 1'b1 || lk_a !== 1'b0 || ec_a !== 8'd3) begin
            $display("FAIL hold_strict got=%b/%b/%0d exp=1/0/3", se_a, lk_a, ec_a); bad++;
        end
        total++;
        if (se_b !== 1'b0 || lk_b !== 1'b1 || ec_b !== 8'd2) begin
            $display("FAIL hold_lenient got=%b/%b/%0d exp=0/1/2", se_b, lk_b, ec_b); bad++;
        end
        total++;
        step(jc[4]);
        if (lk_b !== 1'b1 || se_a !== 1'b0) begin
            $display("FAIL hold_after got=%b/%b exp=1/0", lk_b, se_a); bad++;
        end
        total++;
        cur = 5;
    endtask

    task automatic test_saturate();
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb.delete();
        ma = mreset(); mb = mreset(); mc = mreset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur = 0;
        adv(42);
        if (rc_a !== 8'd5 || rc_c !== 2'd3) begin
            $display("FAIL rev_sat got=%0d/%0d exp=5/3", rc_a, rc_c); bad++;
        end
        total++;
        for (int i = 0; i < 5; i++) begin
            step(ill);
            adv(1);
        end
        adv(1);
        if (ec_a !== 8'd5 || ec_c !== 2'd3) begin
            $display("FAIL err_sat got=%0d/%0d exp=5/3", ec_a, ec_c); bad++;
        end
        total++;
    endtask

    task automatic test_async_reset();
        adv(6);
        if (lk_a !== 1'b1) begin $display("FAIL prereset_lock got=%b exp=1", lk_a); bad++; end
        total++;
        #2;
        rst = 1'b1;
        sb.delete();
        ma = mreset(); mb = mreset(); mc = mreset();
        #1;
        if ({ph_a, vld_a, lk_a, tk_a, se_a, rc_a, ec_a} !== '0 ||
            {ph_c, vld_c, lk_c, tk_c, se_c, rc_c, ec_c} !== '0) begin
            $display("FAIL async_reset got=%h/%h exp=0", {ph_a, vld_a, lk_a, tk_a, se_a, rc_a, ec_a},
                     {ph_c, vld_c, lk_c, tk_c, se_c, rc_c, ec_c});
            bad++;
        end
        total++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(jc[5]); step(jc[6]);
        if (se_a !== 1'b0 || vld_a !== 1'b1 || ph_a !== 3'd5 || lk_a !== 1'b0) begin
            $display("FAIL post_reset_first got=%b/%b/%0d/%b exp=0/1/5/0", se_a, vld_a, ph_a, lk_a);
            bad++;
        end
        total++;
        step(jc[7]); step(jc[0]);
        if (lk_a !== 1'b0) begin $display("FAIL post_reset_early got=%b exp=0", lk_a); bad++; end
        total++;
        step(jc[1]);
        if (lk_a !== 1'b1) begin $display("FAIL post_reset_lock got=%b exp=1", lk_a); bad++; end
        total++;
        step(jc[2]); step(jc[3]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        ma = mreset(); mb = mreset(); mc = mreset();
        test_reset();
        test_lock_and_rev();
        test_bad_step();
        test_illegal();
        test_hold();
        test_saturate();
        test_async_reset();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
